// File: rtl/lif_layer_pkg.sv
// Shared helpers for the spiking layer: width math, default sizes and the
// saturate-then-floor rule applied to every membrane potential update.
package lif_layer_pkg;

  localparam int DEF_NUM_INPUTS  = 4;
  localparam int DEF_NUM_OUTPUTS = 4;
  localparam int DEF_WEIGHT_SIZE = 8;
  localparam int DEF_POT_SIZE    = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int addr_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Refractory counter width; a 1-bit counter stays at zero when refrac is 0.
  function automatic int cnt_width(input int refrac);
    return (clog2(refrac + 1) < 1) ? 1 : clog2(refrac + 1);
  endfunction

  // Saturate v into the signed range of 'width' bits, then floor at floor_v.
  function automatic longint sat_clamp(input longint v, input int width,
                                       input longint floor_v);
    longint hi;
    longint lo;
    longint r;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -hi - 1;
    r  = v;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    if (r < floor_v) r = floor_v;
    return r;
  endfunction

endpackage

// File: rtl/lif_layer_neuron.sv
// One leaky integrate-and-fire neuron. It reports a threshold crossing; the
// layer decides whether that crossing becomes a spike (i_fire) or whether the
// neuron is laterally inhibited (i_inhibit).
module lif_neuron
  import lif_layer_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
  parameter int POT_SIZE    = DEF_POT_SIZE,
  parameter int THRESH      = 15,
  parameter int RESET       = 0,
  parameter int REFRAC      = 5,
  parameter int LEAK        = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [NUM_INPUTS-1:0]             i_spike,
  input  logic [NUM_INPUTS*WEIGHT_SIZE-1:0] i_weights,
  input  logic                              i_fire,
  input  logic                              i_inhibit,
  output logic                              o_cross,
  output logic                              o_spike,
  output logic                              o_busy
);

  localparam int SUM_W = POT_SIZE + clog2(NUM_INPUTS) + 1;
  localparam int CNT_W = cnt_width(REFRAC);

  logic signed [POT_SIZE-1:0] r_pot;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_spike;
  logic signed [SUM_W-1:0]    w_sum;
  longint                     w_sat;
  logic signed [POT_SIZE-1:0] w_next_pot;

  // Weighted sum of this step's spikes, leak removed, saturated and floored.
  always_comb begin
    w_sum = SUM_W'(r_pot);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (i_spike[i]) begin
        w_sum = w_sum + SUM_W'($signed(i_weights[i*WEIGHT_SIZE +: WEIGHT_SIZE]));
      end
    end
    w_sum      = w_sum - SUM_W'(LEAK);
    w_sat      = sat_clamp(longint'(w_sum), POT_SIZE, longint'(RESET));
    w_next_pot = w_sat[POT_SIZE-1:0];
    o_cross    = (r_cnt == '0) && (w_sat >= longint'(THRESH));
  end

  // Potential, refractory count and registered spike; refractory wins over input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pot   <= POT_SIZE'(RESET);
      r_cnt   <= '0;
      r_spike <= 1'b0;
    end else if (en) begin
      r_spike <= 1'b0;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_pot <= POT_SIZE'(RESET);
      end else if (i_fire) begin
        r_spike <= 1'b1;
        r_pot   <= POT_SIZE'(RESET);
        r_cnt   <= CNT_W'(REFRAC);
      end else if (i_inhibit) begin
        r_pot <= POT_SIZE'(RESET);
      end else begin
        r_pot <= w_next_pot;
      end
    end else begin
      r_spike <= 1'b0;
    end
  end

  assign o_spike = r_spike;
  assign o_busy  = (r_cnt != '0);

endmodule

// File: rtl/lif_layer.sv
// Layer of LIF neurons with a run-time writable weight matrix and optional
// winner-take-all lateral inhibition (lowest-index crossing neuron wins).
module lif_layer
  import lif_layer_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
  parameter int POT_SIZE    = DEF_POT_SIZE,
  parameter int THRESH      = 15,
  parameter int RESET       = 0,
  parameter int REFRAC      = 5,
  parameter int LEAK        = 0,
  parameter int WTA         = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_INPUTS-1:0]            spike_in,
  input  logic                             w_we,
  input  logic [addr_w(NUM_OUTPUTS)-1:0]   w_addr_n,
  input  logic [addr_w(NUM_INPUTS)-1:0]    w_addr_i,
  input  logic [WEIGHT_SIZE-1:0]           w_data,
  output logic [NUM_OUTPUTS-1:0]           spike_out,
  output logic [NUM_OUTPUTS-1:0]           refrac_busy
);

  logic [WEIGHT_SIZE-1:0]                          r_w [NUM_OUTPUTS][NUM_INPUTS];
  logic [NUM_OUTPUTS-1:0][NUM_INPUTS*WEIGHT_SIZE-1:0] w_row;
  logic [NUM_OUTPUTS-1:0]                          w_cross;
  logic [NUM_OUTPUTS-1:0]                          w_fire;
  logic [NUM_OUTPUTS-1:0]                          w_inhibit;
  logic                                            w_taken;

  // Weight matrix; a write in an enabled cycle lands after that step used the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_OUTPUTS; n++) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          r_w[n][i] <= '0;
        end
      end
    end else if (w_we && (int'(w_addr_n) < NUM_OUTPUTS) && (int'(w_addr_i) < NUM_INPUTS)) begin
      r_w[w_addr_n][w_addr_i] <= w_data;
    end
  end

  // Flatten each neuron's weight row for its port.
  always_comb begin
    w_row = '0;
    for (int n = 0; n < NUM_OUTPUTS; n++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        w_row[n][i*WEIGHT_SIZE +: WEIGHT_SIZE] = r_w[n][i];
      end
    end
  end

  // Fire selection: every crossing neuron, or only the lowest-index one under WTA.
  always_comb begin
    w_fire  = '0;
    w_taken = 1'b0;
    for (int n = 0; n < NUM_OUTPUTS; n++) begin
      if (WTA != 0) begin
        if (w_cross[n] && !w_taken) begin
          w_fire[n] = 1'b1;
          w_taken   = 1'b1;
        end
      end else begin
        w_fire[n] = w_cross[n];
      end
    end
    w_inhibit = {NUM_OUTPUTS{(WTA != 0) && (|w_cross)}};
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_neuron
    lif_neuron #(
      .NUM_INPUTS (NUM_INPUTS),
      .WEIGHT_SIZE(WEIGHT_SIZE),
      .POT_SIZE   (POT_SIZE),
      .THRESH     (THRESH),
      .RESET      (RESET),
      .REFRAC     (REFRAC),
      .LEAK       (LEAK)
    ) u_neuron (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .i_spike   (spike_in),
      .i_weights (w_row[g]),
      .i_fire    (w_fire[g]),
      .i_inhibit (w_inhibit[g]),
      .o_cross   (w_cross[g]),
      .o_spike   (spike_out[g]),
      .o_busy    (refrac_busy[g])
    );
  end

endmodule

// File: tb/tb_lif_layer.sv
// Bench for lif_layer: four parameterisations share one input stream; each is
// checked against a step-level reference model, plus fixed vector tables and
// hand-written corner-case sequences.
module tb_lif_layer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, w_we;
  logic [3:0] spike_in;
  logic [1:0] w_addr_n, w_addr_i;
  logic [7:0] w_data;
  logic [3:0] so [4];
  logic [3:0] rb [4];
  int         pot_t [4][4];

  // 0: defaults, 1: LEAK=2, 2: POT_SIZE=8/THRESH=127, 3: WTA=1
  lif_layer #(.LEAK(0)) d_def (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .w_we(w_we),
    .w_addr_n(w_addr_n), .w_addr_i(w_addr_i), .w_data(w_data),
    .spike_out(so[0]), .refrac_busy(rb[0]));
  lif_layer #(.LEAK(2)) d_leak (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .w_we(w_we),
    .w_addr_n(w_addr_n), .w_addr_i(w_addr_i), .w_data(w_data),
    .spike_out(so[1]), .refrac_busy(rb[1]));
  lif_layer #(.POT_SIZE(8), .THRESH(127)) d_sat (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .w_we(w_we),
    .w_addr_n(w_addr_n), .w_addr_i(w_addr_i), .w_data(w_data),
    .spike_out(so[2]), .refrac_busy(rb[2]));
  lif_layer #(.WTA(1)) d_wta (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .w_we(w_we),
    .w_addr_n(w_addr_n), .w_addr_i(w_addr_i), .w_data(w_data),
    .spike_out(so[3]), .refrac_busy(rb[3]));

  for (genvar g = 0; g < 4; g++) begin : g_tap
    assign pot_t[0][g] = int'(d_def.g_neuron[g].u_neuron.r_pot);
    assign pot_t[1][g] = int'(d_leak.g_neuron[g].u_neuron.r_pot);
    assign pot_t[2][g] = int'(d_sat.g_neuron[g].u_neuron.r_pot);
    assign pot_t[3][g] = int'(d_wta.g_neuron[g].u_neuron.r_pot);
  end

  // ---------------- reference model ----------------
  typedef struct { int pot_size; int thresh; int refrac; int leak; int wta; } cfg_t;
  cfg_t       cfg [4];
  int         m_pot [4][4];
  int         m_cnt [4][4];
  logic [3:0] m_spk [4];
  int         m_w [4][4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_update(input int r, input int e, input int s, input int we,
                              input int an, input int ai, input int wd);
    if (r != 0) begin
      for (int d = 0; d < 4; d++) begin
        m_spk[d] = '0;
        for (int n = 0; n < 4; n++) begin
          m_pot[d][n] = 0;
          m_cnt[d][n] = 0;
          m_w[d][n]   = 0;
        end
      end
      return;
    end
    for (int d = 0; d < 4; d++) begin
      m_spk[d] = '0;
      if (e != 0) begin
        int     sums [4];
        bit     cr [4];
        int     first;
        longint hi, lo, v;
        first = -1;
        hi = (longint'(1) << (cfg[d].pot_size - 1)) - 1;
        lo = -hi - 1;
        for (int n = 0; n < 4; n++) begin
          cr[n]   = 1'b0;
          sums[n] = 0;
          if (m_cnt[d][n] == 0) begin
            v = longint'(m_pot[d][n] - cfg[d].leak);
            for (int i = 0; i < 4; i++) if (((s >> i) & 1) != 0) v += m_w[n][i];
            if (v > hi) v = hi;
            if (v < lo) v = lo;
            if (v < 0) v = 0;
            sums[n] = int'(v);
            cr[n]   = (v >= cfg[d].thresh);
            if (cr[n] && first < 0) first = n;
          end
        end
        for (int n = 0; n < 4; n++) begin
          if (m_cnt[d][n] != 0) begin
            m_cnt[d][n]--;
            m_pot[d][n] = 0;
          end else if ((cfg[d].wta != 0) ? (n == first) : cr[n]) begin
            m_spk[d][n] = 1'b1;
            m_pot[d][n] = 0;
            m_cnt[d][n] = cfg[d].refrac;
          end else if (cfg[d].wta != 0 && first >= 0) begin
            m_pot[d][n] = 0;
          end else begin
            m_pot[d][n] = sums[n];
          end
        end
      end
    end
    if (we != 0) m_w[an][ai] = wd;
  endtask

  task automatic check_all();
    logic [3:0] b;
    for (int d = 0; d < 4; d++) begin
      for (int n = 0; n < 4; n++) b[n] = (m_cnt[d][n] != 0);
      chk($sformatf("spike_out dut%0d", d), int'(so[d]), int'(m_spk[d]));
      chk($sformatf("refrac_busy dut%0d", d), int'(rb[d]), int'(b));
      for (int n = 0; n < 4; n++)
        chk($sformatf("pot dut%0d n%0d", d, n), pot_t[d][n], m_pot[d][n]);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic apply(input int r, input int e, input int s, input int we,
                       input int an, input int ai, input int wd);
    rst      = 1'(r);
    en       = 1'(e);
    spike_in = 4'(s);
    w_we     = 1'(we);
    w_addr_n = 2'(an);
    w_addr_i = 2'(ai);
    w_data   = 8'(wd);
    @(posedge clk);
    model_update(r, e, s, we, an, ai, wd);
    @(negedge clk);
    check_all();
  endtask

  task automatic step(input int s);
    apply(0, 1, s, 0, 0, 0, 0);
  endtask

  task automatic wr(input int an, input int ai, input int wd);
    apply(0, 0, 0, 1, an, ai, wd);
  endtask

  // ---------------- vector table ----------------
  typedef struct { int r; int e; int s; int we; int an; int ai; int wd;
                   int x_so; int x_rb; int x_pot0; } vec_t;
  vec_t vq[$];

  task automatic add_vec(input int r, input int e, input int s, input int we,
                         input int an, input int ai, input int wd,
                         input int x_so, input int x_rb, input int x_pot0);
    vec_t v;
    v = '{r, e, s, we, an, ai, wd, x_so, x_rb, x_pot0};
    vq.push_back(v);
  endtask

  initial begin
    cfg[0] = '{16, 15, 5, 0, 0};
    cfg[1] = '{16, 15, 5, 2, 0};
    cfg[2] = '{8, 127, 5, 0, 0};
    cfg[3] = '{16, 15, 5, 0, 1};
    rst = 1'b1; en = 1'b0; spike_in = '0; w_we = 1'b0;
    w_addr_n = '0; w_addr_i = '0; w_data = '0;
    @(negedge clk);

    // Expectations below are for the default-parameter instance, neuron 0.
    add_vec(1, 0, 0, 0, 0, 0, 0,   0, 0, 0);
    add_vec(0, 0, 0, 1, 0, 0, 5,   0, 0, 0);
    add_vec(0, 0, 0, 1, 0, 1, 5,   0, 0, 0);
    add_vec(0, 0, 0, 1, 0, 2, 5,   0, 0, 0);
    add_vec(0, 0, 0, 1, 0, 3, 5,   0, 0, 0);
    add_vec(0, 1, 15, 0, 0, 0, 0,  1, 1, 0);   // step 1: 20 >= 15 fires
    for (int k = 0; k < 4; k++)
      add_vec(0, 1, 15, 0, 0, 0, 0, 0, 1, 0); // steps 2..5 refractory
    add_vec(0, 1, 15, 0, 0, 0, 0,  0, 0, 0);   // step 6: last ignored step
    add_vec(0, 1, 15, 0, 0, 0, 0,  1, 1, 0);   // step 7 fires again
    add_vec(0, 0, 0, 0, 0, 0, 0,   0, 1, 0);   // en=0 holds counter
    add_vec(1, 0, 0, 0, 0, 0, 0,   0, 0, 0);   // reset mid-refractory
    add_vec(0, 1, 1, 0, 0, 0, 0,   0, 0, 0);   // weights were cleared
    add_vec(0, 1, 1, 1, 0, 0, 15,  0, 0, 0);   // write with en: old weight used
    add_vec(0, 1, 1, 0, 0, 0, 0,   1, 1, 0);   // new weight fires
    add_vec(1, 0, 0, 0, 0, 0, 0,   0, 0, 0);
    add_vec(0, 0, 0, 1, 0, 1, 7,   0, 0, 0);
    add_vec(0, 1, 2, 0, 0, 0, 0,   0, 0, 7);
    add_vec(0, 1, 2, 0, 0, 0, 0,   0, 0, 14);
    add_vec(0, 1, 2, 0, 0, 0, 0,   1, 1, 0);

    for (int k = 0; k < vq.size(); k++) begin
      apply(vq[k].r, vq[k].e, vq[k].s, vq[k].we, vq[k].an, vq[k].ai, vq[k].wd);
      chk($sformatf("tbl%0d spike_out", k), int'(so[0]), vq[k].x_so);
      chk($sformatf("tbl%0d refrac_busy", k), int'(rb[0]), vq[k].x_rb);
      chk($sformatf("tbl%0d pot0", k), pot_t[0][0], vq[k].x_pot0);
    end

    // Leak and floor: w=3, one spike, then silence; then a negative weight.
    apply(1, 0, 0, 0, 0, 0, 0);
    wr(1, 2, 3);
    step(4'b0100);
    chk("leak pot after spike", pot_t[1][1], 1);
    step(4'b0000);
    chk("leak pot floored", pot_t[1][1], 0);
    wr(1, 2, -10);
    step(4'b0100);
    chk("negative weight floor", pot_t[1][1], 0);
    chk("leak no spike", int'(so[1]), 0);

    // Saturation at 8 bits: 100 then 200 -> 127, fires, never negative.
    apply(1, 0, 0, 0, 0, 0, 0);
    wr(2, 0, 100);
    step(4'b0001);
    chk("sat pot 100", pot_t[2][2], 100);
    chk("sat no spike yet", int'(so[2]), 0);
    step(4'b0001);
    chk("sat spike", int'(so[2]), 4'b0100);
    chk("sat pot reset", pot_t[2][2], 0);

    // Winner-take-all: neurons 1 and 3 both reach 20; neuron 2 sits below threshold.
    apply(1, 0, 0, 0, 0, 0, 0);
    wr(1, 0, 20);
    wr(3, 0, 20);
    wr(2, 0, 5);
    step(4'b0001);
    chk("wta spike", int'(so[3]), 4'b0010);
    chk("wta busy", int'(rb[3]), 4'b0010);
    for (int n = 0; n < 4; n++) chk($sformatf("wta pot n%0d", n), pot_t[3][n], 0);
    step(4'b0001);
    chk("wta next winner", int'(so[3]), 4'b1000);

    // Randomised traffic against the model.
    apply(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      apply(($urandom_range(0, 99) == 0) ? 1 : 0,
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 50)) - 15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
